instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding an in-order fetch queue.
// Define FETCH_SKID_BUFFER_EN for a two-entry queue; otherwise the queue is one entry.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

`ifdef FETCH_SKID_BUFFER_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = DEPTH * 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d, occ_left;
  logic [QW-1:0] q_q, q_d;
  logic [QW-1:0] q_shift, wr_ext, wr_mask;
  logic [CW+5:0] wr_sh;
  logic          pop, push, issue;
  logic [31:0]   redir_tgt;
  logic          unused_pc_lsb;

  assign redir_tgt     = {redirect_pc[31:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign pop      = (occ_q != '0) && out_ready;
  assign occ_left = occ_q - CW'(pop);
  assign issue    = (state_q == S_IDLE) && (occ_left < CW'(DEPTH))
                    && !redirect_valid;
  assign push     = (state_q == S_REQ) && imem_ack && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          fetch_pc_d = addr_q + 32'd4;
        end else if (redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
    // A redirect always wins the next fetch address, even on an ack cycle
    if (redirect_valid) fetch_pc_d = redir_tgt;
  end

  // Queue is a shift register: head in the low 64 bits, tail written at occ_left
  assign wr_sh = {occ_left, 6'd0};

  always_comb begin
    q_shift = pop ? (q_q >> 64) : q_q;
    wr_ext  = QW'({imem_rdata, addr_q}) << wr_sh;
    wr_mask = QW'({64{1'b1}}) << wr_sh;
    q_d     = push ? ((q_shift & ~wr_mask) | wr_ext) : q_shift;
    occ_d   = redirect_valid ? '0 : occ_left + CW'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      q_q        <= q_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign out_valid    = (occ_q != '0);
  assign out_instr    = q_q[63:32];
  assign out_pc       = q_q[31:0];
  assign out_pc_plus4 = q_q[31:0] + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure,
// redirects, reset mid-request and PC wrap.
module tb_instr_fetch_unit;

`ifdef FETCH_SKID_BUFFER_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, redirect_valid;
  logic        out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic [31:0] out_instr, out_pc, out_pc_plus4;

  logic        rst2, req2, ack2, redir2, valid2, ready2;
  logic [31:0] addr2, rdata2, rpc2, instr2, pc2, pc4_2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ K;
  assign rdata2     = addr2 ^ K;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .redirect_valid(redir2), .redirect_pc(rpc2),
    .out_valid(valid2), .out_ready(ready2),
    .out_instr(instr2), .out_pc(pc2),
    .out_pc_plus4(pc4_2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_ack = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0500;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: req=%b valid=%b want 0 0",
               imem_req, out_valid);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h want 0", imem_addr);
    end
    checks++;
    if ($isunknown(out_instr) || $isunknown(out_pc)) begin
      failures++;
      $display("FAIL reset_x: instr=%h pc=%h want known",
               out_instr, out_pc);
    end
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h want 1 0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_a, exp_o;
    int n_req, n_out;
    do_reset();
    imem_ack = 1'b1;
    out_ready = 1'b1;
    exp_a = 0; exp_o = 0; n_req = 0; n_out = 0;
    for (int c = 0; c < 13; c++) begin
      if (imem_req) begin
        checks++;
        if (imem_addr !== exp_a) begin
          failures++;
          $display("FAIL stream_addr: got %h want %h", imem_addr, exp_a);
        end
        exp_a += 4; n_req++;
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== exp_o || out_instr !== (exp_o ^ K)
            || out_pc_plus4 !== exp_o + 4) begin
          failures++;
          $display("FAIL stream_out: pc=%h ins=%h p4=%h want pc %h",
                   out_pc, out_instr, out_pc_plus4, exp_o);
        end
        exp_o += 4; n_out++;
      end
      step();
    end
    checks++;
    if (n_req != 6 || n_out != 6) begin
      failures++;
      $display("FAIL stream_rate: reqs=%0d outs=%0d want 6 6",
               n_req, n_out);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a, exp_o;
    int n_ack, n_out;
    do_reset();
    imem_ack = 1'b1;
    exp_a = 0; exp_o = 0; n_ack = 0; n_out = 0;
    for (int c = 0; c < 11; c++) begin
      if (imem_req) begin
        checks++;
        if (imem_addr !== exp_a) begin
          failures++;
          $display("FAIL bp_addr: got %h want %h", imem_addr, exp_a);
        end
        exp_a += 4; n_ack++;
      end
      step();
    end
    checks++;
    if (n_ack != DEPTH || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_stop: acks=%0d req=%b want %0d 0",
               n_ack, imem_req, DEPTH);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++;
      $display("FAIL bp_head: valid=%b pc=%h want 1 0", out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (imem_req) begin
        checks++;
        if (imem_addr !== exp_a) begin
          failures++;
          $display("FAIL bp_addr2: got %h want %h", imem_addr, exp_a);
        end
        exp_a += 4;
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== exp_o || out_instr !== (exp_o ^ K)) begin
          failures++;
          $display("FAIL bp_order: pc=%h ins=%h want pc %h",
                   out_pc, out_instr, exp_o);
        end
        exp_o += 4; n_out++;
      end
      step();
    end
    checks++;
    if (n_out != (DEPTH == 2 ? 5 : 4)) begin
      failures++;
      $display("FAIL bp_count: outs=%0d want %0d", n_out,
               (DEPTH == 2 ? 5 : 4));
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0010;
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle: req=%b want 0", imem_req);
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL rd_issue: req=%b addr=%h want 1 10",
               imem_req, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL rd_hold: req=%b addr=%h want 1 10",
               imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_drop: req=%b valid=%b want 0 0",
               imem_req, out_valid);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL rd_next: req=%b addr=%h want 1 100",
               imem_req, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100
        || out_instr !== (32'h100 ^ K)) begin
      failures++;
      $display("FAIL rd_out: valid=%b pc=%h ins=%h want 1 100",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    step();
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ra_nopush: req=%b valid=%b want 0 0",
               imem_req, out_valid);
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL ra_issue: req=%b addr=%h want 1 40",
               imem_req, imem_addr);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40
        || imem_req !== (DEPTH == 2)) begin
      failures++;
      $display("FAIL ra_head: valid=%b pc=%h req=%b want 1 40 %b",
               out_valid, out_pc, imem_req, (DEPTH == 2));
    end
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL ra_flush: valid=%b req=%b want 0 0",
               out_valid, imem_req);
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL ra_tgt: req=%b addr=%h want 1 80",
               imem_req, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h80) begin
      failures++;
      $display("FAIL ra_out: valid=%b pc=%h want 1 80", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_midreq();
    do_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL rm_issue: req=%b addr=%h want 1 200",
               imem_req, imem_addr);
    end
    rst = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_reset: req=%b addr=%h valid=%b want 0 0 0",
               imem_req, imem_addr, out_valid);
    end
    rst = 1'b0;
    imem_ack = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_late: req=%b addr=%h valid=%b want 1 0 0",
               imem_req, imem_addr, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== K) begin
      failures++;
      $display("FAIL rm_out: valid=%b pc=%h ins=%h want 1 0 %h",
               out_valid, out_pc, out_instr, K);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [3];
    int na, no;
    ea[0] = 32'hFFFF_FFF8;
    ea[1] = 32'hFFFF_FFFC;
    ea[2] = 32'h0000_0000;
    na = 0; no = 0;
    rst2 = 1'b1;
    ack2 = 1'b1;
    ready2 = 1'b1;
    step();
    step();
    checks++;
    if (req2 !== 1'b0 || addr2 !== 32'hFFFF_FFF8) begin
      failures++;
      $display("FAIL wrap_rst: req=%b addr=%h want 0 fffffff8", req2, addr2);
    end
    rst2 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (req2 && na < 3) begin
        checks++;
        if (addr2 !== ea[na]) begin
          failures++;
          $display("FAIL wrap_addr: got %h want %h", addr2, ea[na]);
        end
        na++;
      end
      if (valid2 && no < 3) begin
        checks++;
        if (pc2 !== ea[no] || pc4_2 !== ea[no] + 32'd4
            || instr2 !== (ea[no] ^ K)) begin
          failures++;
          $display("FAIL wrap_out: pc=%h p4=%h ins=%h want pc %h",
                   pc2, pc4_2, instr2, ea[no]);
        end
        no++;
      end
      step();
    end
    checks++;
    if (na != 3 || no != 3) begin
      failures++;
      $display("FAIL wrap_count: reqs=%0d outs=%0d want 3 3", na, no);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    rst2 = 1'b1;
    ack2 = 1'b0;
    redir2 = 1'b0;
    rpc2 = '0;
    ready2 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_reset_midreq();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
